fire6_expand1_ofm_writer: RTL
=============================

// Module: fire6_expand1_ofm_writer
// PURPOSE
// - Downstream of fire6_expand1: captures the DSP_NO-wide ofm vector on each fire6_expand1_sample pulse.
// - Drains the vector into BANKS parallel feature-map RAM write ports, BANKS channels per cycle.
// - Layout is channel-major, so the next fire layer reads each channel plane contiguously.
// - Drives ram_feedback once all WOUT**2 pixels are written; this closes the fire6_expand1 finish handshake.
// PARAMETERS
// - WOUT    16   output feature-map side; WOUT**2 pixels per layer
// - DSP_NO  256  channels per sample (ofm vector length)
// - WIDTH   16   bits per channel value
// - BANKS   4    parallel RAM write ports; DSP_NO % BANKS == 0
// - BEATS   DSP_NO/BANKS (derived, 64)  drain cycles per pixel
// - ADDR_W  $clog2(BEATS*WOUT**2) (derived, 14)  per-bank address width
// PORTS
// - clk                   in   1                  rising-edge clock
// - rst                   in   1                  async active-high reset
// - fire6_expand1_sample  in   1                  1-cycle pulse; ofm valid and stable in that cycle
// - ofm                   in   WIDTH x [DSP_NO]   unpacked array from fire6_expand1
// - wr_en                 out  BANKS              per-bank write enable
// - wr_addr               out  ADDR_W            common address, all banks
// - wr_data               out  WIDTH x [BANKS]    wr_data[b] = channel beat*BANKS+b
// - busy                  out  1                  high while DRAIN
// - ram_feedback          out  1                  sticky high once layer fully written
// - overrun               out  1                  sticky error (FIRE6_OFM_OVERRUN_CHK_EN only)
// BEHAVIOUR
// - Reset (async, rst=1):
//   - state=IDLE; beat=0; pixel=0.
//   - wr_en=0, wr_addr=0, wr_data=0, busy=0, ram_feedback=0, overrun=0.
//   - Capture buffer contents are don't-care.
// - FSM states IDLE, DRAIN, DONE.
//   - IDLE: sample=1 -> capture all DSP_NO ofm words; go to DRAIN with beat=0.
//   - DRAIN: one beat per cycle, all outputs registered:
//     - wr_en = all ones.
//     - wr_addr = beat*WOUT**2 + pixel.
//     - wr_data[b] = buf[beat*BANKS+b].
//   - Last beat (beat==BEATS-1):
//     - pixel < WOUT**2-1: pixel++ and go to IDLE.
//     - pixel == WOUT**2-1: go to DONE.
//   - DONE: ram_feedback=1, wr_en=0; samples ignored; only rst leaves DONE.
// - Latency: sample at edge t -> first write beat (beat 0) at t+1 -> last beat at t+BEATS.
//   - ram_feedback rises the cycle after the final beat of the last pixel.
// - Simultaneous event: sample in the cycle of the last beat of a non-final pixel:
//   - Capture the new vector and stay in DRAIN with beat=0, pixel++.
//   - No idle gap, no data loss.
//   - This covers back-to-back sampling at the minimum interval CHIN+1=65 >= BEATS+1.
// - Sample in DRAIN before the last beat is an overrun:
//   - The new vector is dropped and the drain in progress continues unaffected.
// - Address arithmetic: beat*WOUT**2 is a shift for power-of-2 WOUT; the sum never wraps within ADDR_W.
// - Reset mid-DRAIN aborts the drain immediately; wr_en=0 in the same cycle (async).
// CONFIGURATION
// - Macro FIRE6_OFM_OVERRUN_CHK_EN.
// - Defined: overrun is set sticky on any sample arriving in DRAIN (except on the last beat) or in DONE.
//   - overrun is cleared only by rst.
// - Undefined: the overrun port is tied 0, no detection logic; samples in those states are silently ignored.
// STRUCTURE
// - Package fire6_pkg holds:
//   - localparams WOUT, DSP_NO, WIDTH, BANKS, BEATS, ADDR_W.
//   - typedef enum logic [1:0] {IDLE, DRAIN, DONE} ofm_wr_state_t.
//   - typedef logic [WIDTH-1:0] fm_word_t.
// - One sub-module, fire6_ofm_addr_gen: beat/pixel counters, wr_addr, last-beat and last-pixel flags.
// - Capture buffer and the BANKS-wide read mux stay in the top module.
// TESTING
// - Single sample, ofm[c]=c:
//   - wr_en=4'hF for 64 cycles starting t+1.
//   - Beat k: wr_addr=k*256, wr_data={4k..4k+3}; busy falls after beat 63.
// - 256 samples every 65 cycles, ofm[c]=pixel*256+c:
//   - Every bank address holds its expected value.
//   - ram_feedback=1 one cycle after final beat; no writes afterward.
// - Sample on the last-beat cycle, back-to-back:
//   - Next pixel beat 0 at the following cycle, addr=pixel+1, no gap, overrun=0.
// - With FIRE6_OFM_OVERRUN_CHK_EN, sample at beat 10:
//   - overrun=1 sticky; the current pixel's data is unchanged.
//   - Without the macro: overrun stays 0, same data.
// - Assert rst at beat 30 of pixel 5:
//   - wr_en=0, busy=0, ram_feedback=0 immediately.
//   - The next sample writes pixel 0 at addr 0.
// - Sample in DONE: no wr_en; ram_feedback stays 1 (overrun=1 if the macro is defined).

Source files
------------

// File: rtl/fire6_pkg.sv
// Shared parameters, types and address helper for the fire6_expand1 ofm writer.
package fire6_pkg;

  localparam int unsigned WOUT   = 16;
  localparam int unsigned DSP_NO = 256;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned BANKS  = 4;
  localparam int unsigned BEATS  = DSP_NO / BANKS;
  localparam int unsigned PIXELS = WOUT * WOUT;
  localparam int unsigned ADDR_W = $clog2(BEATS * PIXELS);
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned PIX_W  = $clog2(PIXELS);
  localparam int unsigned IDX_W  = $clog2(DSP_NO);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} ofm_wr_state_t;

  typedef logic [WIDTH-1:0] fm_word_t;

  // Channel-major layout: each beat owns one contiguous plane of PIXELS words per bank.
  function automatic logic [ADDR_W-1:0] plane_addr(input logic [BEAT_W-1:0] beat,
                                                   input logic [PIX_W-1:0]  pixel);
    return ADDR_W'(beat) * ADDR_W'(PIXELS) + ADDR_W'(pixel);
  endfunction

endpackage

// File: rtl/fire6_ofm_addr_gen.sv
// Beat/pixel counters for the ofm drain and the common per-bank write address.
module fire6_ofm_addr_gen
  import fire6_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [BEAT_W-1:0] beat,
  output logic [ADDR_W-1:0] addr,
  output logic              last_beat,
  output logic              last_pixel
);

  logic [BEAT_W-1:0] beat_q;
  logic [PIX_W-1:0]  pixel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q  <= '0;
      pixel_q <= '0;
    end else if (advance) begin
      if (last_beat) begin
        beat_q <= '0;
        // The final pixel holds; the layer is complete and only reset restarts it.
        if (!last_pixel) begin
          pixel_q <= pixel_q + 1'b1;
        end
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));
  assign last_pixel = (pixel_q == PIX_W'(PIXELS - 1));
  assign beat       = beat_q;
  assign addr       = plane_addr(beat_q, pixel_q);

endmodule

// File: rtl/fire6_expand1_ofm_writer.sv
// Captures fire6_expand1 ofm vectors and drains them BANKS channels per cycle into feature-map RAM.
// Optional macro FIRE6_OFM_OVERRUN_CHK_EN enables the sticky overrun detector.
module fire6_expand1_ofm_writer
  import fire6_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fire6_expand1_sample,
  input  logic [WIDTH-1:0]  ofm [DSP_NO],
  output logic [BANKS-1:0]  wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data [BANKS],
  output logic              busy,
  output logic              ram_feedback,
  output logic              overrun
);

  ofm_wr_state_t state_q, state_d;
  logic          capture;
  logic          advance;

  logic [BEAT_W-1:0] beat;
  logic [ADDR_W-1:0] addr;
  logic              last_beat;
  logic              last_pixel;

  fm_word_t cap_q   [DSP_NO];
  fm_word_t rd_data [BANKS];

  logic [BANKS-1:0]  wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  fm_word_t          wr_data_q [BANKS];
  logic              busy_q;
  logic              rf_q;

  fire6_ofm_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .beat       (beat),
    .addr       (addr),
    .last_beat  (last_beat),
    .last_pixel (last_pixel)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire6_expand1_sample) begin
          capture = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        advance = 1'b1;
        if (last_beat) begin
          if (last_pixel) begin
            state_d = DONE;
          end else if (fire6_expand1_sample) begin
            // Back-to-back pixel: reload and keep draining without an idle gap.
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture contents are don't-care after reset, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_q <= ofm;
    end
  end

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      rd_data[b] = cap_q[IDX_W'(beat) * IDX_W'(BANKS) + IDX_W'(b)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      rf_q      <= 1'b0;
      for (int b = 0; b < BANKS; b++) begin
        wr_data_q[b] <= '0;
      end
    end else begin
      wr_en_q <= {BANKS{state_q == DRAIN}};
      busy_q  <= (state_q == DRAIN);
      rf_q    <= (state_q == DONE);
      if (state_q == DRAIN) begin
        wr_addr_q <= addr;
        wr_data_q <= rd_data;
      end
    end
  end

`ifdef FIRE6_OFM_OVERRUN_CHK_EN
  logic overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (fire6_expand1_sample &&
                 (((state_q == DRAIN) && !last_beat) || (state_q == DONE))) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign ram_feedback = rf_q;

endmodule
